debounce4: RTL and testbench



---
 rtl/debounce4.sv | 123 ++++++++++++
 tb/tb_debounce4.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/debounce4.sv
// Four-channel synchroniser + debouncer feeding the x0..x3 gate inputs.
// Optional macro DEBOUNCE_EDGE_EN adds registered rise/fall strobes.
module debounce4 #(
  parameter int N_STABLE = 120000,
  parameter int CNT_W    = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_in,
  output logic       x0,
  output logic       x1,
  output logic       x2,
  output logic       x3
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic [3:0] rise,
  output logic [3:0] fall
`endif
);

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STABLE - 1);

  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] x_level;
`ifdef DEBOUNCE_EDGE_EN
  logic [3:0] rise_level;
  logic [3:0] fall_level;
`endif

  // Two-flop synchroniser; only sync2_reg is seen by the channel logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_in;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      state_t           state_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             x_reg;
`ifdef DEBOUNCE_EDGE_EN
      logic             rise_reg;
      logic             fall_reg;
`endif
      logic             s;

      assign s = sync2_reg[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= STABLE;
          cnt_reg   <= '0;
          x_reg     <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
`endif
        end else begin
`ifdef DEBOUNCE_EDGE_EN
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
`endif
          case (state_reg)
            STABLE: begin
              if (s != x_reg) begin
                state_reg <= CHANGING;
                cnt_reg   <= CNT_W'(1);
              end
            end
            CHANGING: begin
              if (s == x_reg) begin
                // Bounced back before the window closed: discard silently.
                state_reg <= STABLE;
                cnt_reg   <= '0;
              end else if (cnt_reg == CNT_LAST) begin
                x_reg     <= s;
                state_reg <= STABLE;
                cnt_reg   <= '0;
`ifdef DEBOUNCE_EDGE_EN
                rise_reg  <= s;
                fall_reg  <= ~s;
`endif
              end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
              end
            end
            default: begin
              state_reg <= STABLE;
              cnt_reg   <= '0;
            end
          endcase
        end
      end

      assign x_level[gi] = x_reg;
`ifdef DEBOUNCE_EDGE_EN
      assign rise_level[gi] = rise_reg;
      assign fall_level[gi] = fall_reg;
`endif
    end
  endgenerate

  assign x0 = x_level[0];
  assign x1 = x_level[1];
  assign x2 = x_level[2];
  assign x3 = x_level[3];
`ifdef DEBOUNCE_EDGE_EN
  assign rise = rise_level;
  assign fall = fall_level;
`endif

endmodule

// File: tb/tb_debounce4.sv
// Bench for debounce4 (N_STABLE=4): sample-history model checked every cycle
// plus hand-computed latency checks for each directed scenario.
`timescale 1ns/1ps
module tb_debounce4;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_in = 4'b0000;
  logic       x0, x1, x2, x3;
  logic [3:0] x_vec;
`ifdef DEBOUNCE_EDGE_EN
  logic [3:0] rise, fall;
`endif

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  bit model_valid = 1'b0;

  debounce4 #(.N_STABLE(N), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3)
`ifdef DEBOUNCE_EDGE_EN
    , .rise(rise), .fall(fall)
`endif
  );

  assign x_vec = {x3, x2, x1, x0};

  always #41.665 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, edge_cnt, act, exp);
    end
  endtask

  // Model: a change is accepted once the last N synchronised samples all
  // disagree with the accepted level. Reset empties the sample history.
  logic [3:0] m_s1, m_s2, m_x, m_rise, m_fall;
  logic [3:0] hist[$];
  initial begin
    m_s1 = '0; m_s2 = '0; m_x = '0; m_rise = '0; m_fall = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_s1 = '0; m_s2 = '0; m_x = '0; m_rise = '0; m_fall = '0;
        hist.delete();
      end else begin
        hist.push_back(m_s2);
        if (hist.size() > N) void'(hist.pop_front());
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < 4; c++) begin
          bit all_diff;
          all_diff = (hist.size() == N);
          for (int j = 0; j < hist.size(); j++)
            if (hist[j][c] == m_x[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_x[c] = ~m_x[c];
            if (m_x[c]) m_rise[c] = 1'b1;
            else        m_fall[c] = 1'b1;
          end
        end
        m_s2 = m_s1;
        m_s1 = btn_in;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_x", x_vec, m_x);
`ifdef DEBOUNCE_EDGE_EN
      chk("model_rise", rise, m_rise);
      chk("model_fall", fall, m_fall);
`endif
    end
  end

  task automatic wait_edge(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    int r;
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int r;
    // Reset, then idle: everything stays low.
    rst = 1'b1; btn_in = 4'b0000;
    cycles(3);
    model_valid = 1'b1;
    chk("reset_x", x_vec, 4'b0000);
    rst = 1'b0;
    cycles(20);
    chk("idle_x", x_vec, 4'b0000);

    // Clean press on channel 2.
    btn_in = 4'b0100; k = edge_cnt + 1;
    wait_edge(k + 4); chk("press_early", x_vec, 4'b0000);
    wait_edge(k + 5); chk("press_x", x_vec, 4'b0100);
`ifdef DEBOUNCE_EDGE_EN
    chk("press_rise", rise, 4'b0100);
    wait_edge(k + 6); chk("press_rise_off", rise, 4'b0000);
`endif
    btn_in = 4'b0000;
    cycles(10);
    chk("press_released", x_vec, 4'b0000);

    // Bounce on channel 0: 1,1,0,1,1,1,1 then hold.
    btn_in = 4'b0001; cycles(1);
    btn_in = 4'b0001; cycles(1);
    btn_in = 4'b0000; cycles(1);
    btn_in = 4'b0001; k = edge_cnt + 1;
    wait_edge(k + 4); chk("bounce_early", x_vec, 4'b0000);
    wait_edge(k + 5); chk("bounce_x", x_vec, 4'b0001);
    btn_in = 4'b0000;
    cycles(10);
    // Two-cycle pulse must be rejected.
    btn_in = 4'b0001; cycles(2);
    btn_in = 4'b0000; cycles(10);
    chk("pulse_reject", x_vec, 4'b0000);

    // Simultaneous change on channels 0, 1, 3.
    btn_in = 4'b1011; k = edge_cnt + 1;
    wait_edge(k + 4); chk("simul_early", x_vec, 4'b0000);
    wait_edge(k + 5); chk("simul_x", x_vec, 4'b1011);
`ifdef DEBOUNCE_EDGE_EN
    chk("simul_rise", rise, 4'b1011);
`endif
    cycles(4);
    btn_in = 4'b0000; k = edge_cnt + 1;
    wait_edge(k + 4); chk("release_early", x_vec, 4'b1011);
    wait_edge(k + 5); chk("release_x", x_vec, 4'b0000);
`ifdef DEBOUNCE_EDGE_EN
    chk("release_fall", fall, 4'b1011);
    wait_edge(k + 6); chk("release_fall_off", fall, 4'b0000);
`endif
    cycles(6);

    // Reset mid-count on channel 1 (cnt reaches 2 at edge k+3).
    btn_in = 4'b0010; k = edge_cnt + 1;
    wait_edge(k + 3);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0; r = edge_cnt + 1;
    wait_edge(r + 4); chk("midrst_early", x_vec, 4'b0000);
    wait_edge(r + 5); chk("midrst_x", x_vec, 4'b0010);
    btn_in = 4'b0000;
    cycles(10);

    // Inputs held high through reset.
    btn_in = 4'b1111; rst = 1'b1;
    cycles(3);
    chk("held_in_reset", x_vec, 4'b0000);
    rst = 1'b0; r = edge_cnt + 1;
    wait_edge(r + 4); chk("held_early", x_vec, 4'b0000);
    wait_edge(r + 5); chk("held_x", x_vec, 4'b1111);
`ifdef DEBOUNCE_EDGE_EN
    chk("held_rise", rise, 4'b1111);
    wait_edge(r + 6); chk("held_rise_off", rise, 4'b0000);
`endif
    cycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
